// File: rtl/ec_point_mult_sequencer.sv
// Double-and-add sequencer for Q = k*P, driving one shared point add/double unit.
// Optional op counters are enabled by defining EC_SEQ_OP_COUNT_EN.
module ec_point_mult_sequencer #(
    parameter int P_WIDTH      = 377,
    parameter int SCALAR_WIDTH = 254
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_start,
    input  logic [SCALAR_WIDTH-1:0]   i_scalar,
    input  logic [2*P_WIDTH-1:0]      i_point_in,
    output logic                      o_busy,
    output logic                      o_done,
    output logic [2*P_WIDTH-1:0]      o_result,
    output logic                      o_result_inf,
    output logic                      o_op_valid,
    input  logic                      i_op_ready,
    output logic                      o_op_double,
    output logic [2*P_WIDTH-1:0]      o_op_a,
    output logic [2*P_WIDTH-1:0]      o_op_b,
    input  logic                      i_res_valid,
    input  logic [2*P_WIDTH-1:0]      i_res_point
`ifdef EC_SEQ_OP_COUNT_EN
    ,
    output logic [8:0]                o_dbl_count,
    output logic [8:0]                o_add_count
`endif
);

    localparam int PT_W  = 2 * P_WIDTH;
    localparam int IDX_W = (SCALAR_WIDTH > 1) ? $clog2(SCALAR_WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BIT,
        S_DBL,
        S_DBL_W,
        S_ADD,
        S_ADD_W,
        S_FIN
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [SCALAR_WIDTH-1:0] r_scalar;
    logic [PT_W-1:0]         r_point;
    logic [PT_W-1:0]         r_acc;
    logic                    r_acc_inf;
    logic [IDX_W-1:0]        r_idx;
    logic                    r_busy;
    logic                    r_done;
    logic [PT_W-1:0]         r_result;
    logic                    r_result_inf;

    logic w_bit;
    logic w_last;
    logic w_accept;
    logic w_load;
    logic w_acc_set_p;
    logic w_acc_set_res;
    logic w_idx_dec;
    logic w_finish;

    assign w_bit    = r_scalar[r_idx];
    assign w_last   = (r_idx == '0);
    // The done cycle is already back in IDLE, so r_done blocks a start there.
    assign w_accept = (r_state == S_IDLE) && i_start && !r_done;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_load        = 1'b0;
        w_acc_set_p   = 1'b0;
        w_acc_set_res = 1'b0;
        w_idx_dec     = 1'b0;
        w_finish      = 1'b0;
        o_op_valid    = 1'b0;
        o_op_double   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_load = 1'b1;
                    w_next = ((i_scalar == '0) || (i_point_in == '0)) ? S_FIN : S_BIT;
                end
            end
            S_BIT: begin
                if (!r_acc_inf) begin
                    w_next = S_DBL;
                end else begin
                    w_acc_set_p = w_bit;
                    if (w_last) begin
                        w_next = S_FIN;
                    end else begin
                        w_idx_dec = 1'b1;
                    end
                end
            end
            S_DBL: begin
                o_op_valid  = 1'b1;
                o_op_double = 1'b1;
                if (i_op_ready) begin
                    w_next = S_DBL_W;
                end
            end
            S_DBL_W: begin
                if (i_res_valid) begin
                    w_acc_set_res = 1'b1;
                    if (w_bit) begin
                        w_next = S_ADD;
                    end else if (w_last) begin
                        w_next = S_FIN;
                    end else begin
                        w_idx_dec = 1'b1;
                        w_next    = S_BIT;
                    end
                end
            end
            S_ADD: begin
                o_op_valid = 1'b1;
                if (i_op_ready) begin
                    w_next = S_ADD_W;
                end
            end
            S_ADD_W: begin
                if (i_res_valid) begin
                    w_acc_set_res = 1'b1;
                    if (w_last) begin
                        w_next = S_FIN;
                    end else begin
                        w_idx_dec = 1'b1;
                        w_next    = S_BIT;
                    end
                end
            end
            S_FIN: begin
                w_finish = 1'b1;
                w_next   = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_scalar     <= '0;
            r_point      <= '0;
            r_acc        <= '0;
            r_acc_inf    <= 1'b1;
            r_idx        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_result     <= '0;
            r_result_inf <= 1'b0;
        end else begin
            if (w_load) begin
                r_scalar  <= i_scalar;
                r_point   <= i_point_in;
                r_idx     <= IDX_W'(SCALAR_WIDTH - 1);
                r_acc     <= '0;
                r_acc_inf <= 1'b1;
                r_busy    <= 1'b1;
            end
            if (w_acc_set_p) begin
                r_acc     <= r_point;
                r_acc_inf <= 1'b0;
            end
            if (w_acc_set_res) begin
                r_acc <= i_res_point;
            end
            if (w_idx_dec) begin
                r_idx <= r_idx - IDX_W'(1);
            end
            r_done <= w_finish;
            // Infinity is reported as the flag plus an all-zero point.
            if (w_finish) begin
                r_busy       <= 1'b0;
                r_result     <= r_acc_inf ? '0 : r_acc;
                r_result_inf <= r_acc_inf;
            end
        end
    end

    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_result     = r_result;
    assign o_result_inf = r_result_inf;
    assign o_op_a       = r_acc;
    assign o_op_b       = r_point;

`ifdef EC_SEQ_OP_COUNT_EN
    logic       w_handshake;
    logic [8:0] r_dbl_count;
    logic [8:0] r_add_count;

    assign w_handshake = o_op_valid && i_op_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dbl_count <= '0;
            r_add_count <= '0;
        end else if (w_load) begin
            r_dbl_count <= '0;
            r_add_count <= '0;
        end else if (w_handshake) begin
            if (o_op_double) begin
                r_dbl_count <= r_dbl_count + 9'd1;
            end else begin
                r_add_count <= r_add_count + 9'd1;
            end
        end
    end

    assign o_dbl_count = r_dbl_count;
    assign o_add_count = r_add_count;
`endif

endmodule
